tmip_gray_conv: RTL and testbench

TMIP_GRAY_CONV -- requirements
Module: tmip_gray_conv

---
 rtl/tmip_gray_conv.sv | 172 +++++++++++++++++
 tb/tb_tmip_gray_conv.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmip_gray_conv.sv
`default_nettype none
// ============================================================================
// Module   : tmip_gray_conv
// Brief    : Streams R,G,B (or pre-gray) samples and writes max/avg/weighted
//            grayscale per pixel with raster address and end-of-frame pulse.
// Revision : 1.0
// ============================================================================
module tmip_gray_conv #(
    parameter  int DATA_W   = 8,
    parameter  int CHANNELS = 3,
    parameter  int MAX_SIDE = 16,
    localparam int ADDR_W   = $clog2(MAX_SIDE * MAX_SIDE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] image,
    input  logic [1:0]        image_size,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] gray_max,
    output logic [DATA_W-1:0] gray_avg,
    output logic [DATA_W-1:0] gray_wgt,
    output logic              done
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SUM_W = DATA_W + 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         size_q, size_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [ADDR_W-1:0]  pix_q, pix_d;
    logic               wr_en_q, wr_en_d;
    logic               done_q, done_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  gmax_q, gmax_d;
    logic [DATA_W-1:0]  gavg_q, gavg_d;
    logic [DATA_W-1:0]  gwgt_q, gwgt_d;

    logic [1:0]         w_code;
    logic [ADDR_W-1:0]  w_last_pix;
    logic               w_last_ch;
    logic [DATA_W-1:0]  w_max, w_avg, w_wgt;

    function automatic logic [ADDR_W-1:0] last_pix_of(input logic [1:0] code);
        int side;
        case (code)
            2'd0:    side = 4;
            2'd1:    side = 8;
            default: side = 16;
        endcase
        if (side > MAX_SIDE) side = MAX_SIDE;
        return ADDR_W'(side * side - 1);
    endfunction

    generate
        if (CHANNELS == 1) begin : g_mono
            assign w_max = image;
            assign w_avg = image;
            assign w_wgt = image;
        end else begin : g_rgb
            logic [DATA_W-1:0] r_q, r_d, g_q, g_d;
            logic [DATA_W-1:0] mx_rg;
            logic [SUM_W-1:0]  sum;

            always_comb begin
                r_d = r_q;
                g_d = g_q;
                if (in_valid && ch_q == CH_W'(0)) r_d = image;
                if (in_valid && ch_q == CH_W'(1)) g_d = image;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                    g_q <= '0;
                end else begin
                    r_q <= r_d;
                    g_q <= g_d;
                end
            end

            // Blue is never stored: it arrives in the same cycle the pixel completes.
            assign mx_rg = (r_q > g_q) ? r_q : g_q;
            assign w_max = (mx_rg > image) ? mx_rg : image;
            assign sum   = SUM_W'(r_q) + SUM_W'(g_q) + SUM_W'(image);
            assign w_avg = DATA_W'(sum / SUM_W'(3));
            assign w_wgt = (r_q >> 2) + (g_q >> 1) + (image >> 2);
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        ch_d      = ch_q;
        pix_d     = pix_q;
        wr_en_d   = 1'b0;
        done_d    = 1'b0;
        wr_addr_d = wr_addr_q;
        gmax_d    = gmax_q;
        gavg_d    = gavg_q;
        gwgt_d    = gwgt_q;

        // The frame size is only trusted on the sample that opens a frame.
        w_code     = (state_q == IDLE) ? image_size : size_q;
        w_last_pix = last_pix_of(w_code);
        w_last_ch  = (ch_q == CH_W'(CHANNELS - 1));

        if (in_valid) begin
            if (state_q == IDLE) size_d = image_size;
            state_d = LOAD;
            if (w_last_ch) begin
                ch_d      = '0;
                wr_en_d   = 1'b1;
                wr_addr_d = pix_q;
                gmax_d    = w_max;
                gavg_d    = w_avg;
                gwgt_d    = w_wgt;
                if (pix_q == w_last_pix) begin
                    done_d  = 1'b1;
                    pix_d   = '0;
                    state_d = IDLE;
                end else begin
                    pix_d = pix_q + ADDR_W'(1);
                end
            end else begin
                ch_d = ch_q + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            size_q    <= '0;
            ch_q      <= '0;
            pix_q     <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            wr_addr_q <= '0;
            gmax_q    <= '0;
            gavg_q    <= '0;
            gwgt_q    <= '0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            ch_q      <= ch_d;
            pix_q     <= pix_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
            wr_addr_q <= wr_addr_d;
            gmax_q    <= gmax_d;
            gavg_q    <= gavg_d;
            gwgt_q    <= gwgt_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign done     = done_q;
    assign wr_addr  = wr_addr_q;
    assign gray_max = gmax_q;
    assign gray_avg = gavg_q;
    assign gray_wgt = gwgt_q;

endmodule
`default_nettype wire

// File: tb/tb_tmip_gray_conv.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmip_gray_conv
// Brief    : Scoreboard bench for tmip_gray_conv (RGB 8-bit and mono 10-bit).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_tmip_gray_conv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid;
    logic [7:0] image;
    logic [1:0] image_size;
    logic       wr_en, done;
    logic [7:0] wr_addr, gray_max, gray_avg, gray_wgt;

    logic       in_valid1;
    logic [9:0] image1;
    logic [1:0] image_size1;
    logic       wr_en1, done1;
    logic [7:0] wr_addr1;
    logic [9:0] gray_max1, gray_avg1, gray_wgt1;

    tmip_gray_conv dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .image(image),
        .image_size(image_size), .wr_en(wr_en), .wr_addr(wr_addr),
        .gray_max(gray_max), .gray_avg(gray_avg), .gray_wgt(gray_wgt), .done(done)
    );

    tmip_gray_conv #(.DATA_W(10), .CHANNELS(1), .MAX_SIDE(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .image(image1),
        .image_size(image_size1), .wr_en(wr_en1), .wr_addr(wr_addr1),
        .gray_max(gray_max1), .gray_avg(gray_avg1), .gray_wgt(gray_wgt1), .done(done1)
    );

    typedef struct {
        logic [7:0] addr;
        logic [9:0] mx;
        logic [9:0] av;
        logic [9:0] wg;
        logic       dn;
    } exp_t;

    exp_t q3[$];
    exp_t q1[$];
    exp_t e3, e1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_wr3 = 0;
    int   n_done3 = 0;
    int   n_wr1 = 0;

    function automatic exp_t mk(input int a, input int r, input int g, input int b, input bit dn);
        exp_t e;
        int   m;
        m = r;
        if (g > m) m = g;
        if (b > m) m = b;
        e.addr = 8'(a);
        e.mx   = 10'(m);
        e.av   = 10'((r + g + b) / 3);
        e.wg   = 10'((r >> 2) + (g >> 1) + (b >> 2));
        e.dn   = dn;
        return e;
    endfunction

    function automatic exp_t mkc(input int a, input int mx, input int av, input int wg, input bit dn);
        exp_t e;
        e.addr = 8'(a);
        e.mx   = 10'(mx);
        e.av   = 10'(av);
        e.wg   = 10'(wg);
        e.dn   = dn;
        return e;
    endfunction

    always @(negedge clk) begin
        if (wr_en) begin
            n_wr3++;
            if (done) n_done3++;
            n_cmp++;
            if (q3.size() == 0) begin
                n_err++;
                $display("FAIL wr3_unexpected: got write addr=%0d, required none", wr_addr);
            end else begin
                e3 = q3.pop_front();
                if (wr_addr !== e3.addr || gray_max !== e3.mx[7:0] || gray_avg !== e3.av[7:0] ||
                    gray_wgt !== e3.wg[7:0] || done !== e3.dn) begin
                    n_err++;
                    $display("FAIL wr3: got addr=%0d max=%0d avg=%0d wgt=%0d done=%0b, required addr=%0d max=%0d avg=%0d wgt=%0d done=%0b",
                             wr_addr, gray_max, gray_avg, gray_wgt, done, e3.addr, e3.mx, e3.av, e3.wg, e3.dn);
                end
            end
        end else if (done) begin
            n_cmp++;
            n_err++;
            $display("FAIL done3_alone: got done=1 with wr_en=0, required done=0");
        end
    end

    always @(negedge clk) begin
        if (wr_en1) begin
            n_wr1++;
            n_cmp++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL wr1_unexpected: got write addr=%0d, required none", wr_addr1);
            end else begin
                e1 = q1.pop_front();
                if (wr_addr1 !== e1.addr || gray_max1 !== e1.mx || gray_avg1 !== e1.av ||
                    gray_wgt1 !== e1.wg || done1 !== e1.dn) begin
                    n_err++;
                    $display("FAIL wr1: got addr=%0d max=%0d avg=%0d wgt=%0d done=%0b, required addr=%0d max=%0d avg=%0d wgt=%0d done=%0b",
                             wr_addr1, gray_max1, gray_avg1, gray_wgt1, done1, e1.addr, e1.mx, e1.av, e1.wg, e1.dn);
                end
            end
        end else if (done1) begin
            n_cmp++;
            n_err++;
            $display("FAIL done1_alone: got done=1 with wr_en=0, required done=0");
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic s3(input logic [7:0] d, input logic [1:0] sz);
        in_valid   = 1'b1;
        image      = d;
        image_size = sz;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
    endtask

    task automatic s1(input logic [9:0] d, input logic [1:0] sz);
        in_valid1   = 1'b1;
        image1      = d;
        image_size1 = sz;
        @(posedge clk);
        #1;
        in_valid1   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((q3.size() != 0 || q1.size() != 0) && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(name, 32'(q3.size() + q1.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, d0, r, g, b;
        rst_n = 1'b0;
        in_valid = 1'b0; image = '0; image_size = '0;
        in_valid1 = 1'b0; image1 = '0; image_size1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_gray", 32'({gray_max, gray_avg, gray_wgt}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 16 identical pixels, continuous stream
        for (int p = 0; p < 16; p++) begin
            q3.push_back(mkc(p, 30, 20, 19, p == 15));
            s3(8'd10, 2'd0); s3(8'd20, 2'd0); s3(8'd30, 2'd0);
        end
        chk("lat_done", 32'(done), 32'd1);
        chk("lat_addr", 32'(wr_addr), 32'd15);
        drain("drain_basic");

        // Saturated input: sum must not overflow
        for (int p = 0; p < 16; p++) begin
            q3.push_back(mkc(p, 255, 255, 253, p == 15));
            s3(8'd255, 2'd0); s3(8'd255, 2'd0); s3(8'd255, 2'd0);
        end
        drain("drain_sat");

        // Size 1 with stalls and image_size changing mid-frame
        w0 = n_wr3; d0 = n_done3;
        for (int p = 0; p < 64; p++) begin
            r = (p * 7 + 3) & 255;
            g = (p * 13 + 100) & 255;
            b = (255 - p * 3) & 255;
            q3.push_back(mk(p, r, g, b, p == 63));
            s3(8'(r), (p == 0) ? 2'd1 : 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 5));
            s3(8'(g), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 5));
            s3(8'(b), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 5));
        end
        drain("drain_gaps");
        chk("gaps_writes", 32'(n_wr3 - w0), 32'd64);
        chk("gaps_dones", 32'(n_done3 - d0), 32'd1);

        // Reset in the middle of a size-2 frame, with a partial pixel pending
        for (int p = 0; p < 6; p++) begin
            q3.push_back(mk(p, 40 + p, 90, 200, 1'b0));
            s3(8'(40 + p), 2'd2); s3(8'd90, 2'd2); s3(8'd200, 2'd2);
        end
        s3(8'd250, 2'd2); s3(8'd250, 2'd2);
        drain("drain_pre_rst");
        chk("pre_rst_addr", 32'(wr_addr), 32'd5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_addr", 32'(wr_addr), 32'd0);
        chk("arst_gray", 32'({gray_max, gray_avg, gray_wgt}), 32'd0);
        chk("arst_wr_done", 32'({wr_en, done}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
        w0 = n_wr3;
        for (int p = 0; p < 16; p++) begin
            q3.push_back(mk(p, p * 10, 5, 77, p == 15));
            s3(8'(p * 10), 2'd0); s3(8'd5, 2'd0); s3(8'd77, 2'd0);
        end
        drain("drain_post_rst");
        chk("post_rst_writes", 32'(n_wr3 - w0), 32'd16);

        // Two frames back-to-back, second frame starts in the done cycle
        w0 = n_wr3; d0 = n_done3;
        for (int p = 0; p < 32; p++) begin
            q3.push_back(mk(p % 16, 100 + p, 3 * p, 60, (p % 16) == 15));
            s3(8'(100 + p), 2'd0); s3(8'(3 * p), 2'd0); s3(8'd60, 2'd0);
        end
        drain("drain_b2b");
        chk("b2b_writes", 32'(n_wr3 - w0), 32'd32);
        chk("b2b_dones", 32'(n_done3 - d0), 32'd2);

        // Mono 10-bit instance, 16x16 ramp
        for (int i = 0; i < 256; i++) begin
            q1.push_back(mkc(i, i, i, i, i == 255));
            s1(10'(i), 2'd2);
        end
        drain("drain_mono");
        chk("mono_writes", 32'(n_wr1), 32'd256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
